lpd_hit_logger: RTL and testbench

- Downstream consumer of the LPD pattern detector.
- Samples LPD's per-cycle outputs: flag, count, fin, and the addr it is presenting. Records the address of every detected pattern in a small show-ahead FIFO.
- Drains that FIFO over a valid/ready read port.
- Cross-checks LPD's running count against its own hit counter and exposes sticky error and done status for the system controller.

---
 rtl/lpd_hit_logger.sv | 124 ++++++++++++
 tb/tb_lpd_hit_logger.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/lpd_hit_logger.sv
// Logs addresses of LPD pattern hits into a show-ahead FIFO and cross-checks LPD's running count.
// Optional build macro LPD_LOG_DEDUP_EN suppresses repeated hits on the same address.
module lpd_hit_logger #(
    parameter int AW    = 10,
    parameter int CW    = 4,
    parameter int DEPTH = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] det_addr,
    input  logic          det_flag,
    input  logic [CW-1:0] det_count,
    input  logic          det_fin,
    input  logic          rd_ready,
    output logic          rd_valid,
    output logic [AW-1:0] rd_addr,
    output logic [CW-1:0] hit_total,
    output logic          busy,
    output logic          done,
    output logic          err_cnt,
    output logic          err_ovf
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_OCC = (PW+1)'(DEPTH);

    typedef enum logic [1:0] {
        S_COLLECT,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t        state, state_nx;
    logic [AW-1:0] mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr, rd_ptr_nx;
    logic [PW:0]   occ, occ_mid, occ_nx;
    logic          hit, push, pop, full, is_repeat;

`ifdef LPD_LOG_DEDUP_EN
    logic [AW-1:0] last_addr;
    logic          last_valid;

    assign is_repeat = last_valid && (det_addr == last_addr);

    always_ff @(posedge clk) begin
        if (rst) begin
            last_valid <= 1'b0;
            last_addr  <= '0;
        end else if (hit) begin
            last_valid <= 1'b1;
            last_addr  <= det_addr;
        end
    end
`else
    assign is_repeat = 1'b0;
`endif

    assign hit       = (state == S_COLLECT) && det_flag && !is_repeat;
    assign full      = (occ == FULL_OCC);
    assign pop       = rd_valid && rd_ready;
    assign push      = hit && (!full || pop);
    assign occ_mid   = occ - {{PW{1'b0}}, pop};
    assign occ_nx    = occ_mid + {{PW{1'b0}}, push};
    assign rd_ptr_nx = pop ? rd_ptr + PW'(1) : rd_ptr;
    assign busy      = (state != S_DONE);
    assign done      = (state == S_DONE);

    always_ff @(posedge clk) begin
        if (!rst && push) begin
            mem[wr_ptr] <= det_addr;
        end
    end

    // The head register is refilled from the slot rd_ptr will point at next,
    // bypassing memory when the pushed entry is the only one left.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_COLLECT;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occ       <= '0;
            rd_valid  <= 1'b0;
            rd_addr   <= '0;
            hit_total <= '0;
            err_cnt   <= 1'b0;
            err_ovf   <= 1'b0;
        end else begin
            state    <= state_nx;
            occ      <= occ_nx;
            rd_ptr   <= rd_ptr_nx;
            rd_valid <= (occ_nx != '0);
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (occ_mid == '0) begin
                if (push) begin
                    rd_addr <= det_addr;
                end
            end else begin
                rd_addr <= mem[rd_ptr_nx];
            end
            if (hit) begin
                hit_total <= hit_total + CW'(1);
                if (det_count != hit_total + CW'(1)) begin
                    err_cnt <= 1'b1;
                end
                if (full && !pop) begin
                    err_ovf <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_COLLECT: if (det_fin) state_nx = S_DRAIN;
            S_DRAIN:   if (occ == '0) state_nx = S_DONE;
            S_DONE:    state_nx = S_DONE;
            default:   state_nx = S_COLLECT;
        endcase
    end

endmodule

// File: tb/tb_lpd_hit_logger.sv
// Directed self-checking bench for lpd_hit_logger: a vector table for the basic
// hit/count flow plus hand-written overflow, drain, done and repeat sequences.
module tb_lpd_hit_logger;

    logic       clk;
    logic       rst;
    logic [9:0] det_addr;
    logic       det_flag;
    logic [3:0] det_count;
    logic       det_fin;
    logic       rd_ready;
    logic       rd_valid;
    logic [9:0] rd_addr;
    logic [3:0] hit_total;
    logic       busy;
    logic       done;
    logic       err_cnt;
    logic       err_ovf;

    int total = 0;
    int bad   = 0;

    lpd_hit_logger #(.AW(10), .CW(4), .DEPTH(16)) dut (
        .clk(clk), .rst(rst),
        .det_addr(det_addr), .det_flag(det_flag), .det_count(det_count), .det_fin(det_fin),
        .rd_ready(rd_ready), .rd_valid(rd_valid), .rd_addr(rd_addr), .hit_total(hit_total),
        .busy(busy), .done(done), .err_cnt(err_cnt), .err_ovf(err_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [9:0] addr;
        logic       flag;
        logic [3:0] cnt;
        logic       fin;
        logic       ready;
        logic       evalid;
        logic [9:0] eaddr;
        logic [3:0] etotal;
        logic       ebusy;
        logic       edone;
        logic       eerrc;
        logic       eerro;
    } vec_t;

    vec_t vecs[14];

    function automatic vec_t mkv(logic r, int a, logic f, int c, logic fi, logic rd,
                                 logic ev, int ea, int et, logic eb, logic ed,
                                 logic ec, logic eo);
        vec_t v;
        v.rst = r; v.addr = 10'(a); v.flag = f; v.cnt = 4'(c); v.fin = fi; v.ready = rd;
        v.evalid = ev; v.eaddr = 10'(ea); v.etotal = 4'(et); v.ebusy = eb; v.edone = ed;
        v.eerrc = ec; v.eerro = eo;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic r, input int a, input logic f, input int c,
                                 input logic fi, input logic rd);
        rst = r; det_addr = 10'(a); det_flag = f; det_count = 4'(c); det_fin = fi; rd_ready = rd;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic ev, input int ea, input int et,
                               input logic eb, input logic ed, input logic ec, input logic eo);
        chk({tag, ".rd_valid"},  32'(rd_valid),  32'(ev));
        chk({tag, ".rd_addr"},   32'(rd_addr),   32'(ea));
        chk({tag, ".hit_total"}, 32'(hit_total), 32'(et));
        chk({tag, ".busy"},      32'(busy),      32'(eb));
        chk({tag, ".done"},      32'(done),      32'(ed));
        chk({tag, ".err_cnt"},   32'(err_cnt),   32'(ec));
        chk({tag, ".err_ovf"},   32'(err_ovf),   32'(eo));
    endtask

    initial begin
        int n;

        //                 rst addr flg cnt fin rdy  | vld addr tot bsy dn ec eo
        vecs[0]  = mkv(1, 3,   1, 5, 1, 1,  0, 0,   0, 1, 0, 0, 0);
        vecs[1]  = mkv(1, 3,   1, 5, 1, 1,  0, 0,   0, 1, 0, 0, 0);
        vecs[2]  = mkv(0, 5,   1, 1, 0, 1,  1, 5,   1, 1, 0, 0, 0);
        vecs[3]  = mkv(0, 17,  1, 2, 0, 1,  1, 17,  2, 1, 0, 0, 0);
        vecs[4]  = mkv(0, 900, 1, 3, 0, 1,  1, 900, 3, 1, 0, 0, 0);
        vecs[5]  = mkv(0, 1,   0, 9, 0, 1,  0, 900, 3, 1, 0, 0, 0);
        vecs[6]  = mkv(1, 0,   0, 0, 0, 0,  0, 0,   0, 1, 0, 0, 0);
        vecs[7]  = mkv(0, 11,  1, 1, 0, 0,  1, 11,  1, 1, 0, 0, 0);
        vecs[8]  = mkv(0, 12,  1, 2, 0, 0,  1, 11,  2, 1, 0, 0, 0);
        vecs[9]  = mkv(0, 40,  1, 7, 0, 0,  1, 11,  3, 1, 0, 1, 0);
        vecs[10] = mkv(0, 0,   0, 0, 0, 1,  1, 12,  3, 1, 0, 1, 0);
        vecs[11] = mkv(0, 0,   0, 0, 0, 1,  1, 40,  3, 1, 0, 1, 0);
        vecs[12] = mkv(0, 0,   0, 0, 0, 1,  0, 40,  3, 1, 0, 1, 0);
        vecs[13] = mkv(0, 0,   0, 9, 0, 0,  0, 40,  3, 1, 0, 1, 0);

        rst = 1'b1; det_addr = '0; det_flag = 1'b0; det_count = '0; det_fin = 1'b0; rd_ready = 1'b0;
        #1;

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].rst, int'(vecs[i].addr), vecs[i].flag, int'(vecs[i].cnt),
                          vecs[i].fin, vecs[i].ready);
            checkOutput($sformatf("vec%0d", i), vecs[i].evalid, int'(vecs[i].eaddr),
                        int'(vecs[i].etotal), vecs[i].ebusy, vecs[i].edone,
                        vecs[i].eerrc, vecs[i].eerro);
        end

        // 17 hits with the sink stalled: the 17th is dropped, total wraps to 1
        applyStimulus(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 17; i++) begin
            applyStimulus(0, i, 1, (i + 1) % 16, 0, 0);
            if (i == 15) chk("ovf.full_no_err", 32'(err_ovf), 0);
        end
        checkOutput("ovf.after17", 1, 0, 1, 1, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 1, 0);
        checkOutput("ovf.fin", 1, 0, 1, 1, 0, 0, 1);
        for (int k = 0; k < 16; k++) begin
            chk($sformatf("drain.valid%0d", k), 32'(rd_valid), 1);
            chk($sformatf("drain.addr%0d", k), 32'(rd_addr), 32'(k));
            applyStimulus(0, 999, 1, 0, 0, 1);
        end
        checkOutput("drain.empty", 0, 15, 1, 1, 0, 0, 1);
        applyStimulus(0, 999, 1, 0, 1, 1);
        checkOutput("drain.done", 0, 15, 1, 0, 1, 0, 1);
        applyStimulus(0, 3, 1, 2, 1, 1);
        checkOutput("done.hold", 0, 15, 1, 0, 1, 0, 1);

        // full FIFO, push with simultaneous pop is accepted
        applyStimulus(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 16; i++) applyStimulus(0, 100 + i, 1, (i + 1) % 16, 0, 0);
        checkOutput("full.pre", 1, 100, 0, 1, 0, 0, 0);
        applyStimulus(0, 500, 1, 1, 0, 1);
        checkOutput("full.pushpop", 1, 101, 1, 1, 0, 0, 0);
        for (int k = 0; k < 16; k++) begin
            chk($sformatf("full.drain%0d", k), 32'(rd_addr), (k < 15) ? 32'(101 + k) : 32'd500);
            applyStimulus(0, 0, 0, 0, 0, 1);
        end
        chk("full.empty", 32'(rd_valid), 0);

        // fin into an empty FIFO reaches DONE after two edges
        applyStimulus(1, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 1, 0);
        checkOutput("fin.empty1", 0, 0, 0, 1, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("fin.empty2", 0, 0, 0, 0, 1, 0, 0);

        // hit on the fin cycle is still logged and must drain first
        applyStimulus(1, 0, 0, 0, 0, 0);
        applyStimulus(0, 77, 1, 1, 1, 0);
        checkOutput("finhit.log", 1, 77, 1, 1, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 1);
        checkOutput("finhit.pop", 0, 77, 1, 1, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 1);
        checkOutput("finhit.done", 0, 77, 1, 0, 1, 0, 0);

        // flag held on one address for three cycles; a pre-reset hit at 88 must be forgotten
        applyStimulus(1, 0, 0, 0, 0, 0);
        applyStimulus(0, 88, 1, 1, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) applyStimulus(0, 88, 1, 1, 0, 0);
`ifdef LPD_LOG_DEDUP_EN
        checkOutput("rep.state", 1, 88, 1, 1, 0, 0, 0);
`else
        checkOutput("rep.state", 1, 88, 3, 1, 0, 1, 0);
`endif
        n = 0;
        for (int c = 0; c < 20; c++) begin
            if (rd_valid) begin
                n++;
                chk($sformatf("rep.addr%0d", n), 32'(rd_addr), 88);
            end
            applyStimulus(0, 0, 0, 0, 0, 1);
        end
`ifdef LPD_LOG_DEDUP_EN
        chk("rep.entries", 32'(n), 1);
`else
        chk("rep.entries", 32'(n), 3);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
